// File: rtl/pair_triple_stim_gen_pkg.sv
// pair_triple_stim_gen_pkg: shared state encoding, sweep length and golden
// detector function for the pair/triple detector self-test.
package pair_triple_stim_gen_pkg;

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

   localparam int NUM_VECS = 8;

   // Golden detector: output is 1 when at least two of the three inputs are 1.
   function automatic logic majority3(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

endpackage

// File: rtl/pair_triple_stim_gen_ref.sv
// pair_triple_ref: combinational golden model of the pair/triple detector.
module pair_triple_ref
   import pair_triple_stim_gen_pkg::*;
(
   input  logic [2:0] vec,
   output logic       expected
);

   assign expected = majority3(vec);

endmodule

// File: rtl/pair_triple_stim_gen.sv
// pair_triple_stim_gen: sweeps all 3-bit detector input vectors, holds each for
// HOLD_CYCLES, samples the detector output and tallies mismatches against the golden model.
module pair_triple_stim_gen
   import pair_triple_stim_gen_pkg::*;
#(
   parameter int HOLD_CYCLES = 2,
   parameter int ERR_W       = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             det_in,
   output logic [2:0]       stim,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic             fail_valid,
   output logic [2:0]       fail_vec
);

   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
   localparam logic [2:0] LAST_VEC = 3'(NUM_VECS - 1);

   state_t           state, state_nx;
   logic [2:0]       vec, vec_nx, stim_nx, fail_vec_nx;
   logic [HW-1:0]    hold, hold_nx;
   logic [ERR_W-1:0] err_nx;
   logic             fail_valid_nx, expected;

   pair_triple_ref u_ref (
      .vec      (vec),
      .expected (expected)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         vec        <= '0;
         hold       <= '0;
         stim       <= '0;
         err_count  <= '0;
         fail_valid <= 1'b0;
         fail_vec   <= '0;
      end else begin
         state      <= state_nx;
         vec        <= vec_nx;
         hold       <= hold_nx;
         stim       <= stim_nx;
         err_count  <= err_nx;
         fail_valid <= fail_valid_nx;
         fail_vec   <= fail_vec_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      vec_nx        = vec;
      hold_nx       = hold;
      stim_nx       = stim;
      err_nx        = err_count;
      fail_valid_nx = fail_valid;
      fail_vec_nx   = fail_vec;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nx      = DRIVE;
               vec_nx        = '0;
               hold_nx       = HOLD_LOAD;
               stim_nx       = '0;
               err_nx        = '0;
               fail_valid_nx = 1'b0;
               fail_vec_nx   = '0;
            end
         end
         DRIVE: begin
            if (hold == '0) state_nx = SAMPLE;
            else hold_nx = hold - 1'b1;
         end
         SAMPLE: begin
            // Only the first mismatch is latched; the counter saturates instead of wrapping.
            if (det_in != expected) begin
               err_nx = &err_count ? err_count : err_count + 1'b1;
               if (!fail_valid) begin
                  fail_valid_nx = 1'b1;
                  fail_vec_nx   = vec;
               end
            end
            if (vec == LAST_VEC) begin
               state_nx = DONE;
               stim_nx  = '0;
            end else begin
               state_nx = DRIVE;
               vec_nx   = vec + 3'd1;
               stim_nx  = vec + 3'd1;
               hold_nx  = HOLD_LOAD;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign busy = (state == DRIVE) || (state == SAMPLE);
   assign done = (state == DONE);
   assign pass = done && (err_count == '0);

endmodule

// File: doc/pair_triple_stim_gen.md
Name: pair_triple_stim_gen

Overview:
- Drive side of the pair/triple detector interface: generates the three detector input lines and checks the single detector output line.
- Sweeps all 8 input vectors, holds each vector for a programmable settle time, then samples the returned detector bit and compares it against a built-in golden model (out = 1 when at least 2 of 3 bits are 1).
- Sits in the tile wrapper in front of the detector, or drives external pins, for on-silicon self-test.

Parameters:
- HOLD_CYCLES, 2, cycles each vector is driven before the sample cycle. Legal range is 1 or more.
- ERR_W, 4, width of the saturating error counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a sweep; sampled in IDLE and DONE only
- det_in  in  1  detector output being checked
- stim  out  3  detector inputs; stim[0]=in0, stim[1]=in1, stim[2]=in2
- busy  out  1  sweep in progress (DRIVE or SAMPLE)
- done  out  1  sweep complete; held until the next start
- pass  out  1  valid when done=1; 1 when err_count==0
- err_count  out  ERR_W  mismatches counted; saturates at all-ones
- fail_valid  out  1  at least one mismatch seen in this sweep
- fail_vec  out  3  vector of the first mismatch; valid when fail_valid=1

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, stim=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_vec=0, vector counter vec=0, hold counter=0.
- Reset asserted mid-sweep aborts immediately to these values. No partial result is retained.
- State machine states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE, start=1 at a clock edge:
  - Go to DRIVE with vec=0.
  - Clear err_count, fail_valid, fail_vec.
  - Load hold counter.
- DRIVE:
  - stim=vec, busy=1.
  - Stay for exactly HOLD_CYCLES cycles, then go to SAMPLE.
- SAMPLE:
  - stim stays at vec, busy=1. Lasts 1 cycle.
  - At the closing edge, compare det_in against expected(vec). expected=1 for vec in {3,5,6,7}, else 0.
  - On a mismatch:
    - err_count increments, saturating at all-ones.
    - If fail_valid=0: set fail_valid=1 and fail_vec=vec.
  - If vec==7: go to DONE. Otherwise vec+1 and go to DRIVE.
- DONE:
  - stim=0, busy=0, done=1, pass=(err_count==0).
  - Results are held.
  - start=1 restarts exactly as from IDLE: done drops in the next cycle and results are cleared.
- start is ignored in DRIVE and SAMPLE. There is no abort except reset.
- Timing: each vector takes HOLD_CYCLES+1 cycles. done rises 8*(HOLD_CYCLES+1) edges after the start-accepting edge (24 edges for the default).
- stim is registered, never combinational from start. det_in is sampled only in SAMPLE, so glitches during DRIVE are don't-care.
- The sequence has no wrap-around past vec=7. A single sweep is performed per start.

Decomposition:
- Shared package holds:
  - state enum (IDLE, DRIVE, SAMPLE, DONE);
  - constant NUM_VECS=8;
  - golden function majority3(vec) returning the expected detector output.
- One combinational sub-module, pair_triple_ref, implements the golden model. It is reused by the bench scoreboard.
- Everything else lives in one FSM + counters module.

Test Plan:
- Default params, det_in fed by a correct detector model (stim→majority), pulse start → busy for 24 cycles, then done=1, pass=1, err_count=0, fail_valid=0, stim=000; stim steps 0..7, each value held 3 cycles.
- det_in tied 0 → done after 24 cycles, err_count=4, pass=0, fail_valid=1, fail_vec=3.
- det_in tied 1 → err_count=4, fail_vec=0.
- det_in = inverted correct output, ERR_W=2 → err_count saturates at 3, fail_vec=0, pass=0.
- start pulsed again at vec=4 during a sweep → ignored; done still at cycle 24. Then start in DONE → done=0 next cycle, err_count cleared, new sweep of 24 cycles.
- rst_n low during SAMPLE of vec=5 (asynchronous, mid-cycle) → all outputs go to reset values immediately. After release with no start, IDLE is held and stim=000.
